// File: rtl/idex_pipe_reg_pkg.sv
// Shared widths, control-bundle bit positions and update selector
// for the ID/EX pipeline register.
package idex_pipe_reg_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int REG_ADDR_W_DEF = 5;
    localparam int ALUOP_W_DEF    = 3;
    localparam int CNT_W_DEF      = 16;

    localparam int CB_WB      = 0;
    localparam int CB_MTR     = 1;
    localparam int CB_MR      = 2;
    localparam int CB_MW      = 3;
    localparam int CB_BRANCH  = 4;
    localparam int CB_REGDST  = 5;
    localparam int CB_ALUSRC  = 6;
    localparam int CB_LH      = 7;
    localparam int CB_LHU     = 8;
    localparam int CTRL_W     = 9;

    typedef enum logic [1:0] {
        UPD_LOAD,
        UPD_HOLD,
        UPD_FLUSH,
        UPD_HAZ
    } upd_e;

endpackage

// File: rtl/idex_hazard_detect.sv
// Load-use hazard compare between the EX slot and the decoding
// instruction; purely combinational.
module idex_hazard_detect
    import idex_pipe_reg_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  ex_valid_i,
    input  logic                  ex_mr_i,
    input  logic [REG_ADDR_W-1:0] ex_rt_i,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    output logic                  hazard_o
);

    logic rt_nz;
    logic rt_hit;

    assign rt_nz  = |ex_rt_i;
    assign rt_hit = (ex_rt_i == id_rs_i) | (ex_rt_i == id_rt_i);

    assign hazard_o = ex_valid_i & ex_mr_i & id_valid_i & rt_nz & rt_hit;

endmodule

// File: rtl/idex_pipe_reg.sv
// ID/EX pipeline register with hold, flush and load-use bubble
// insertion; hazard_stall freezes PC and IF/ID upstream.
module idex_pipe_reg
    import idex_pipe_reg_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int ALUOP_W    = ALUOP_W_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  stall_ext,
    input  logic                  flush,
    input  logic                  In_WB,
    input  logic                  In_MemtoReg,
    input  logic                  In_MR,
    input  logic                  In_MW,
    input  logic                  In_branch,
    input  logic                  In_RegDst,
    input  logic                  In_ALUsrc,
    input  logic                  In_LoadHalf,
    input  logic                  In_LoadHalfUnsigned,
    input  logic [ALUOP_W-1:0]    In_ALUop,
    input  logic [DATA_W-1:0]     In_address,
    input  logic [DATA_W-1:0]     In_Readdata1,
    input  logic [DATA_W-1:0]     In_Readdata2,
    input  logic [DATA_W-1:0]     In_extended,
    input  logic [REG_ADDR_W-1:0] In_rs,
    input  logic [REG_ADDR_W-1:0] In_rt,
    input  logic [REG_ADDR_W-1:0] In_rd,
    input  logic [REG_ADDR_W-1:0] In_shamt,
    output logic                  out_valid,
    output logic                  out_WB,
    output logic                  out_MemtoReg,
    output logic                  out_MR,
    output logic                  out_MW,
    output logic                  out_branch,
    output logic                  out_RegDst,
    output logic                  out_ALUsrc,
    output logic                  out_LoadHalf,
    output logic                  out_LoadHalfUnsigned,
    output logic [ALUOP_W-1:0]    out_ALUop,
    output logic [DATA_W-1:0]     out_address,
    output logic [DATA_W-1:0]     out_Readdata1,
    output logic [DATA_W-1:0]     out_Readdata2,
    output logic [DATA_W-1:0]     out_extended,
    output logic [REG_ADDR_W-1:0] out_rs,
    output logic [REG_ADDR_W-1:0] out_rt,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic [REG_ADDR_W-1:0] out_shamt,
    output logic                  hazard_stall,
    output logic [CNT_W-1:0]      bubble_count
);

    logic [CTRL_W-1:0]     ctrl_in;
    logic                  valid_q, valid_d;
    logic [CTRL_W-1:0]     ctrl_q, ctrl_d;
    logic [ALUOP_W-1:0]    aluop_q, aluop_d;
    logic [DATA_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     rd1_q, rd1_d;
    logic [DATA_W-1:0]     rd2_q, rd2_d;
    logic [DATA_W-1:0]     ext_q, ext_d;
    logic [REG_ADDR_W-1:0] rs_q, rs_d;
    logic [REG_ADDR_W-1:0] rt_q, rt_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic [REG_ADDR_W-1:0] shamt_q, shamt_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  haz;
    upd_e                  upd;

    always_comb begin
        ctrl_in            = '0;
        ctrl_in[CB_WB]     = In_WB;
        ctrl_in[CB_MTR]    = In_MemtoReg;
        ctrl_in[CB_MR]     = In_MR;
        ctrl_in[CB_MW]     = In_MW;
        ctrl_in[CB_BRANCH] = In_branch;
        ctrl_in[CB_REGDST] = In_RegDst;
        ctrl_in[CB_ALUSRC] = In_ALUsrc;
        ctrl_in[CB_LH]     = In_LoadHalf;
        ctrl_in[CB_LHU]    = In_LoadHalfUnsigned;
    end

    idex_hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard (
        .ex_valid_i (valid_q),
        .ex_mr_i    (ctrl_q[CB_MR]),
        .ex_rt_i    (rt_q),
        .id_valid_i (in_valid),
        .id_rs_i    (In_rs),
        .id_rt_i    (In_rt),
        .hazard_o   (haz)
    );

    // Several sources may be active at once, so priority, not unique.
    always_comb begin
        priority case (1'b1)
            flush:     upd = UPD_FLUSH;
            stall_ext: upd = UPD_HOLD;
            haz:       upd = UPD_HAZ;
            default:   upd = UPD_LOAD;
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        aluop_d = aluop_q;
        addr_d  = addr_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        ext_d   = ext_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        shamt_d = shamt_q;
        cnt_d   = cnt_q;
        case (upd)
            UPD_FLUSH, UPD_HAZ: begin
                valid_d = 1'b0;
                ctrl_d  = '0;
                aluop_d = '0;
                addr_d  = '0;
                rd1_d   = '0;
                rd2_d   = '0;
                ext_d   = '0;
                rs_d    = '0;
                rt_d    = '0;
                rd_d    = '0;
                shamt_d = '0;
                if (upd == UPD_HAZ && !(&cnt_q)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            UPD_LOAD: begin
                valid_d = in_valid;
                ctrl_d  = in_valid ? ctrl_in : '0;
                aluop_d = in_valid ? In_ALUop : '0;
                addr_d  = In_address;
                rd1_d   = In_Readdata1;
                rd2_d   = In_Readdata2;
                ext_d   = In_extended;
                rs_d    = In_rs;
                rt_d    = In_rt;
                rd_d    = In_rd;
                shamt_d = In_shamt;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            aluop_q <= '0;
            addr_q  <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            ext_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            shamt_q <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            aluop_q <= aluop_d;
            addr_q  <= addr_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            ext_q   <= ext_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            shamt_q <= shamt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid            = valid_q;
    assign out_WB               = ctrl_q[CB_WB];
    assign out_MemtoReg         = ctrl_q[CB_MTR];
    assign out_MR               = ctrl_q[CB_MR];
    assign out_MW               = ctrl_q[CB_MW];
    assign out_branch           = ctrl_q[CB_BRANCH];
    assign out_RegDst           = ctrl_q[CB_REGDST];
    assign out_ALUsrc           = ctrl_q[CB_ALUSRC];
    assign out_LoadHalf         = ctrl_q[CB_LH];
    assign out_LoadHalfUnsigned = ctrl_q[CB_LHU];
    assign out_ALUop            = aluop_q;
    assign out_address          = addr_q;
    assign out_Readdata1        = rd1_q;
    assign out_Readdata2        = rd2_q;
    assign out_extended         = ext_q;
    assign out_rs               = rs_q;
    assign out_rt               = rt_q;
    assign out_rd               = rd_q;
    assign out_shamt            = shamt_q;
    assign hazard_stall         = haz;
    assign bubble_count         = cnt_q;

endmodule

// File: tb/tb_idex_pipe_reg.sv
// Randomised scoreboard bench for idex_pipe_reg; expected EX-slot
// contents are queued by the stimulus and popped by a monitor.
module tb_idex_pipe_reg;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic        valid;
        logic [8:0]  ctrl;
        logic [2:0]  aluop;
        logic [31:0] addr;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] ext;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [CNT_W-1:0] cnt;
    } st_t;

    logic clk = 1'b0;
    logic rst, in_valid, stall_ext, flush;
    logic In_WB, In_MemtoReg, In_MR, In_MW, In_branch;
    logic In_RegDst, In_ALUsrc, In_LoadHalf, In_LoadHalfUnsigned;
    logic [2:0]  In_ALUop;
    logic [31:0] In_address, In_Readdata1, In_Readdata2, In_extended;
    logic [4:0]  In_rs, In_rt, In_rd, In_shamt;
    logic out_valid, out_WB, out_MemtoReg, out_MR, out_MW;
    logic out_branch, out_RegDst, out_ALUsrc;
    logic out_LoadHalf, out_LoadHalfUnsigned;
    logic [2:0]  out_ALUop;
    logic [31:0] out_address, out_Readdata1, out_Readdata2;
    logic [31:0] out_extended;
    logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
    logic hazard_stall;
    logic [CNT_W-1:0] bubble_count;

    int total = 0;
    int bad   = 0;
    st_t m;
    st_t exp_q[$];

    idex_pipe_reg #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .stall_ext(stall_ext), .flush(flush),
        .In_WB(In_WB), .In_MemtoReg(In_MemtoReg), .In_MR(In_MR),
        .In_MW(In_MW), .In_branch(In_branch), .In_RegDst(In_RegDst),
        .In_ALUsrc(In_ALUsrc), .In_LoadHalf(In_LoadHalf),
        .In_LoadHalfUnsigned(In_LoadHalfUnsigned),
        .In_ALUop(In_ALUop), .In_address(In_address),
        .In_Readdata1(In_Readdata1), .In_Readdata2(In_Readdata2),
        .In_extended(In_extended), .In_rs(In_rs), .In_rt(In_rt),
        .In_rd(In_rd), .In_shamt(In_shamt),
        .out_valid(out_valid), .out_WB(out_WB),
        .out_MemtoReg(out_MemtoReg), .out_MR(out_MR), .out_MW(out_MW),
        .out_branch(out_branch), .out_RegDst(out_RegDst),
        .out_ALUsrc(out_ALUsrc), .out_LoadHalf(out_LoadHalf),
        .out_LoadHalfUnsigned(out_LoadHalfUnsigned),
        .out_ALUop(out_ALUop), .out_address(out_address),
        .out_Readdata1(out_Readdata1), .out_Readdata2(out_Readdata2),
        .out_extended(out_extended), .out_rs(out_rs), .out_rt(out_rt),
        .out_rd(out_rd), .out_shamt(out_shamt),
        .hazard_stall(hazard_stall), .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    function automatic st_t inputs_now();
        st_t s;
        s.valid = in_valid;
        s.ctrl  = {In_LoadHalfUnsigned, In_LoadHalf, In_ALUsrc,
                   In_RegDst, In_branch, In_MW, In_MR, In_MemtoReg,
                   In_WB};
        s.aluop = In_ALUop;
        s.addr  = In_address;
        s.rd1   = In_Readdata1;
        s.rd2   = In_Readdata2;
        s.ext   = In_extended;
        s.rs    = In_rs;
        s.rt    = In_rt;
        s.rd    = In_rd;
        s.shamt = In_shamt;
        s.cnt   = '0;
        return s;
    endfunction

    task automatic set_zero();
        rst = 0; flush = 0; stall_ext = 0; in_valid = 0;
        {In_WB, In_MemtoReg, In_MR, In_MW, In_branch} = '0;
        {In_RegDst, In_ALUsrc, In_LoadHalf, In_LoadHalfUnsigned} = '0;
        In_ALUop = '0;
        In_address = '0; In_Readdata1 = '0;
        In_Readdata2 = '0; In_extended = '0;
        In_rs = '0; In_rt = '0; In_rd = '0; In_shamt = '0;
    endtask

    task automatic set_rand();
        in_valid = ($urandom_range(0, 4) != 0);
        {In_WB, In_MemtoReg, In_MW, In_branch} = 4'($urandom());
        {In_RegDst, In_ALUsrc, In_LoadHalf} = 3'($urandom());
        In_LoadHalfUnsigned = 1'($urandom());
        In_MR = ($urandom_range(0, 4) < 2);
        In_ALUop = 3'($urandom());
        In_address = $urandom();
        In_Readdata1 = $urandom();
        In_Readdata2 = $urandom();
        In_extended = $urandom();
        In_rs = 5'($urandom_range(0, 3));
        In_rt = 5'($urandom_range(0, 3));
        In_rd = 5'($urandom());
        In_shamt = 5'($urandom());
    endtask

    // Called just after inputs change at the falling edge.
    task automatic apply();
        logic eh;
        logic [CNT_W-1:0] c;
        #1;
        eh = m.valid && m.ctrl[2] && in_valid && (m.rt != 0)
             && (m.rt == In_rs || m.rt == In_rt);
        if (!rst) begin
            total++;
            if (hazard_stall !== eh) begin
                bad++;
                $display("FAIL hazard_stall t=%0t got=%b want=%b",
                         $time, hazard_stall, eh);
            end
        end
        c = m.cnt;
        if (rst) begin
            m = '0;
        end else if (flush) begin
            m = '0;
            m.cnt = c;
        end else if (stall_ext) begin
            m = m;
        end else if (eh) begin
            m = '0;
            m.cnt = (int'(c) >= CNT_MAX) ? c : c + 1'b1;
        end else begin
            m = inputs_now();
            if (!in_valid) begin
                m.ctrl  = '0;
                m.aluop = '0;
            end
            m.cnt = c;
        end
        exp_q.push_back(m);
    endtask

    initial begin : monitor
        st_t a, e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a.valid = out_valid;
                a.ctrl  = {out_LoadHalfUnsigned, out_LoadHalf, out_ALUsrc,
                           out_RegDst, out_branch, out_MW, out_MR,
                           out_MemtoReg, out_WB};
                a.aluop = out_ALUop;
                a.addr  = out_address;
                a.rd1   = out_Readdata1;
                a.rd2   = out_Readdata2;
                a.ext   = out_extended;
                a.rs    = out_rs;
                a.rt    = out_rt;
                a.rd    = out_rd;
                a.shamt = out_shamt;
                a.cnt   = bubble_count;
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL ex_slot t=%0t got=%h want=%h",
                             $time, a, e);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin : stim
        m = '0;
        set_zero();
        rst = 1;
        // Reset with every input nonzero.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            set_rand();
            rst = 1; flush = 1; stall_ext = 1; in_valid = 1;
            In_MR = 1; In_WB = 1;
            apply();
        end
        // Plain load of a decoded instruction.
        @(negedge clk);
        set_zero();
        in_valid = 1; In_Readdata1 = 32'h1234_5678;
        In_ALUop = 3'b010; In_WB = 1; In_rd = 5'd9;
        apply();
        // Load-use pair, then the held instruction loads.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            set_zero();
            in_valid = 1; In_MR = 1; In_rt = 5'd5;
            apply();
            @(negedge clk);
            set_zero();
            in_valid = 1; In_rs = (k % 2 == 0) ? 5'd5 : 5'd0;
            In_rt = (k % 2 == 0) ? 5'd0 : 5'd5;
            In_Readdata2 = 32'hCAFE_0000 + 32'(k);
            apply();
            @(negedge clk);
            apply();
        end
        // Load of rt=0 and non-matching consumer: no bubble.
        @(negedge clk);
        set_zero();
        in_valid = 1; In_MR = 1; In_rt = 5'd0;
        apply();
        @(negedge clk);
        In_MR = 0; In_rs = 5'd0;
        apply();
        @(negedge clk);
        set_zero();
        in_valid = 1; In_MR = 1; In_rt = 5'd5;
        apply();
        @(negedge clk);
        In_MR = 0; In_rs = 5'd3; In_rt = 5'd4;
        apply();
        // External hold with changing inputs, then flush over hold.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_rand();
            stall_ext = 1;
            apply();
        end
        @(negedge clk);
        set_rand();
        stall_ext = 1; flush = 1;
        apply();
        // Reset asserted while a hazard is pending.
        @(negedge clk);
        set_zero();
        in_valid = 1; In_MR = 1; In_rt = 5'd6; In_WB = 1;
        apply();
        @(negedge clk);
        In_rs = 5'd6; rst = 1;
        apply();
        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            set_rand();
            rst       = ($urandom_range(0, 59) == 0);
            flush     = ($urandom_range(0, 9) == 0);
            stall_ext = ($urandom_range(0, 5) == 0);
            apply();
        end
        @(negedge clk);
        set_zero();
        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
